imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the instruction memory and the Riscv core. It accepts a little-endian byte stream (word count header followed by instruction words), writes each assembled 32-bit instruction into the instruction memory, and holds the core in reset until the program is complete. It also publishes the program's byte-address limit, which the core wrap logic compares against `pc` to restart execution at 0.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Loader state encoding and stream framing sizes.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    HDR,
    LOAD,
    DRAIN,
    RUN
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer.
// Presents the assembled word combinationally alongside the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sr;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + 2'd1;
      r_sr  <= {i_byte, r_sr[23:8]};
    end
  end

  // Earlier bytes have shifted down, so the newest byte lands on top.
  assign o_word       = {i_byte, r_sr};
  assign o_word_valid = i_valid &&
                        (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a sized program into instruction memory
// and holds the core in reset until the last word is written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic [31:0] instr_limit,
  output logic        done
);

  state_t r_state;
  state_t w_next;

  logic             w_acc;
  logic [31:0]      w_word;
  logic             w_word_valid;
  logic             w_hdr_done;
  logic             w_word_done;
  logic             w_in_range;
  logic             w_last;

  logic [31:0]      r_n;
  logic [31:0]      r_idx;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             r_we;
  logic [31:0]      r_waddr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_limit;

  assign in_ready = (r_state == HDR) ||
                    (r_state == LOAD);
  assign w_acc    = in_valid && in_ready;

  byte_packer u_pack (
    .clk          (clk),
    .i_clear      (reset),
    .i_valid      (w_acc),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_hdr_done  = (r_state == HDR) && w_word_valid;
  assign w_word_done = (r_state == LOAD) && w_word_valid;
  assign w_in_range  = r_idx < 32'(DEPTH);
  assign w_last      = w_word_done &&
                       ((r_idx + 32'd1) == r_n);

  always_ff @(posedge clk) begin
    if (reset) r_state <= HDR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HDR: begin
        if (w_hdr_done)
          w_next = (w_word == 32'd0) ? RUN : LOAD;
      end
      LOAD: begin
        if (w_last) w_next = DRAIN;
      end
      DRAIN:   w_next = RUN;
      RUN:     w_next = RUN;
      default: w_next = HDR;
    endcase
  end

  // Words past DEPTH advance r_idx but never reach memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n      <= '0;
      r_idx    <= '0;
      r_wr_cnt <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_limit  <= '0;
    end else begin
      r_we <= w_word_done && w_in_range;
      if (w_hdr_done) begin
        r_n   <= w_word;
        r_idx <= '0;
      end
      if (w_word_done) begin
        r_idx <= r_idx + 32'd1;
        if (w_in_range) begin
          r_waddr  <= r_idx << 2;
          r_wdata  <= w_word;
          r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        end
      end
      if (r_state == DRAIN)
        r_limit <= 32'(r_wr_cnt) << 2;
    end
  end

  assign imem_we     = r_we;
  assign imem_waddr  = r_waddr;
  assign imem_wdata  = r_wdata;
  assign instr_limit = r_limit;
  assign core_reset  = (r_state != RUN);
  assign done        = (r_state == RUN);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: full-depth and DEPTH=2 instances driven
// in parallel, checked against a stream-level reference model.
module tb_imem_loader;

  typedef logic [63:0] wr_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        a_rdy, a_we, a_crst, a_done;
  logic [31:0] a_addr, a_data, a_lim;
  logic        b_rdy, b_we, b_crst, b_done;
  logic [31:0] b_addr, b_data, b_lim;

  int tests = 0;
  int fails = 0;

  wr_t        got_a[$];
  wr_t        got_b[$];
  logic [7:0] stim[$];

  imem_loader #(.DEPTH(256)) u_a (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (a_rdy),
    .imem_we     (a_we),
    .imem_waddr  (a_addr),
    .imem_wdata  (a_data),
    .core_reset  (a_crst),
    .instr_limit (a_lim),
    .done        (a_done)
  );

  imem_loader #(.DEPTH(2)) u_b (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (b_rdy),
    .imem_we     (b_we),
    .imem_waddr  (b_addr),
    .imem_wdata  (b_data),
    .core_reset  (b_crst),
    .instr_limit (b_lim),
    .done        (b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (a_we) got_a.push_back({a_addr, a_data});
    if (b_we) got_b.push_back({b_addr, b_data});
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
  endtask

  // Expected memory image and limit straight from the stream framing.
  function automatic void model(input logic [7:0] s[$],
                                input int depth,
                                output wr_t exp[$],
                                output logic [31:0] lim);
    logic [31:0] n;
    logic [31:0] w;
    exp = {};
    n = {s[3], s[2], s[1], s[0]};
    for (int i = 0; i < int'(n); i++) begin
      w = {s[4+4*i+3], s[4+4*i+2], s[4+4*i+1], s[4+4*i]};
      if (i < depth) exp.push_back({32'(i * 4), w});
    end
    lim = ((n < 32'(depth)) ? n : 32'(depth)) * 32'd4;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] s[$], input int ngap);
    int idle[];
    idle = new[s.size()];
    foreach (idle[i]) idle[i] = 0;
    for (int g = 0; g < ngap; g++)
      idle[$urandom_range(1, s.size() - 1)]++;
    for (int i = 0; i < s.size(); i++) begin
      in_valid = 1'b0;
      for (int j = 0; j < idle[i]; j++) begin
        @(negedge clk);
        chk("idle_ready", {a_rdy, b_rdy}, 2'b11);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      @(negedge clk);
      chk("byte_ready", {a_rdy, b_rdy}, 2'b11);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_prog(input logic [7:0] s[$],
                          input int ngap,
                          input string tag);
    wr_t         ea[$];
    wr_t         eb[$];
    logic [31:0] la, lb;
    logic [31:0] n;
    model(s, 256, ea, la);
    model(s, 2, eb, lb);
    n = {s[3], s[2], s[1], s[0]};
    got_a.delete();
    got_b.delete();
    send_bytes(s, ngap);
    @(negedge clk);
    if (n != 0) begin
      chk({tag, "_k1_crst"}, {a_crst, b_crst}, 2'b11);
      chk({tag, "_k1_done"}, {a_done, b_done}, 2'b00);
      chk({tag, "_k1_ready"}, {a_rdy, b_rdy}, 2'b00);
      @(negedge clk);
    end
    chk({tag, "_run_done"}, {a_done, b_done}, 2'b11);
    chk({tag, "_run_crst"}, {a_crst, b_crst}, 2'b00);
    chk({tag, "_run_ready"}, {a_rdy, b_rdy}, 2'b00);
    repeat (2) @(negedge clk);
    chk({tag, "_a_nwr"}, 64'(got_a.size()), 64'(ea.size()));
    chk({tag, "_b_nwr"}, 64'(got_b.size()), 64'(eb.size()));
    foreach (ea[i])
      if (i < got_a.size()) chk({tag, "_a_wr"}, got_a[i], ea[i]);
    foreach (eb[i])
      if (i < got_b.size()) chk({tag, "_b_wr"}, got_b[i], eb[i]);
    chk({tag, "_a_lim"}, 64'(a_lim), 64'(la));
    chk({tag, "_b_lim"}, 64'(b_lim), 64'(lb));
    @(posedge clk); #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(a_rdy), 64'(1));
    chk("rst_we", 64'(a_we), 64'(0));
    chk("rst_addr", 64'(a_addr), 64'(0));
    chk("rst_data", 64'(a_data), 64'(0));
    chk("rst_crst", 64'(a_crst), 64'(1));
    chk("rst_lim", 64'(a_lim), 64'(0));
    chk("rst_done", 64'(a_done), 64'(0));
    @(posedge clk); #1;

    stim = {};
    push_w(32'd2);
    push_w(32'h00100293);
    push_w(32'h00228313);
    run_prog(stim, 0, "two");
    chk("two_w0", got_a[0], {32'h0, 32'h00100293});
    chk("two_lim", 64'(a_lim), 64'(8));

    do_reset();
    stim = {};
    push_w(32'd0);
    run_prog(stim, 0, "empty");

    do_reset();
    stim = {};
    push_w(32'd2);
    push_w(32'h00100293);
    push_w(32'h00228313);
    run_prog(stim, 3, "gap");

    do_reset();
    stim = {};
    push_w(32'd3);
    push_w(32'h11111111);
    push_w(32'h22222222);
    push_w(32'h33333333);
    run_prog(stim, 0, "ovf");
    chk("ovf_b_lim", 64'(b_lim), 64'(8));

    do_reset();
    got_a.delete();
    stim = {};
    push_w(32'd1);
    stim.push_back(8'hAA);
    stim.push_back(8'hBB);
    send_bytes(stim, 0);
    @(negedge clk);
    chk("mid_nowr", 64'(got_a.size()), 64'(0));
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("mid_post_we", {a_we, b_we}, 2'b00);
    chk("mid_post_crst", 64'(a_crst), 64'(1));
    @(posedge clk); #1;
    stim = {};
    push_w(32'd1);
    push_w(32'hDDCCBBAA);
    run_prog(stim, 0, "mid");
    chk("mid_w0", got_a[0], {32'h0, 32'hDDCCBBAA});

    do_reset();
    @(negedge clk);
    chk("runrst_crst", {a_crst, b_crst}, 2'b11);
    chk("runrst_done", {a_done, b_done}, 2'b00);
    chk("runrst_ready", {a_rdy, b_rdy}, 2'b11);
    @(posedge clk); #1;

    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(0, 5);
      stim = {};
      push_w(32'(n));
      for (int i = 0; i < n; i++) push_w($urandom);
      do_reset();
      run_prog(stim, $urandom_range(0, 4), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
